// File: rtl/pc_sched_if.sv
// Interface bundling the next-PC scheduler's request inputs and PC-control outputs.
interface pc_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pc_cur;
  logic             hazard_stall;
  logic             md_start;
  logic             md_ready;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp_valid;
  logic [WIDTH-1:0] jmp_target;
  logic             trap_req;
  logic             eret;
  logic [WIDTH-1:0] pc_in;
  logic             use_pc_in;
  logic             isStall;
  logic             flush_fd;
  logic             flush_dx;
  logic [WIDTH-1:0] epc;
  logic             md_timeout;
  logic [31:0]      stall_cycles;
  logic [31:0]      redirect_count;

  modport master (
    output pc_cur, hazard_stall, md_start, md_ready, br_taken, br_target,
           jmp_valid, jmp_target, trap_req, eret,
    input  pc_in, use_pc_in, isStall, flush_fd, flush_dx, epc, md_timeout,
           stall_cycles, redirect_count
  );

  modport slave (
    input  pc_cur, hazard_stall, md_start, md_ready, br_taken, br_target,
           jmp_valid, jmp_target, trap_req, eret,
    output pc_in, use_pc_in, isStall, flush_fd, flush_dx, epc, md_timeout,
           stall_cycles, redirect_count
  );
endinterface

// File: rtl/pc_sched.sv
// Next-PC scheduler: arbitrates redirects against stalls and parks redirects during multdiv waits.
// Optional perf counters enabled by defining PC_SCHED_PERF_CNT_EN.
module pc_sched #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      TRAP_VEC   = WIDTH'(32'd1),
  parameter int unsigned           MD_TIMEOUT = 64
) (
  input logic       clock,
  input logic       clrn,
  pc_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_in_c;
  logic             use_pc_in_c;
  logic             stall_c;
  logic             flush_fd_c;
  logic             flush_dx_c;
  logic             md_timeout_c;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_target;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_RUN;
      epc_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      epc_q         <= epc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    cnt_d         = cnt_q;
    pc_in_c       = '0;
    use_pc_in_c   = 1'b0;
    stall_c       = 1'b0;
    flush_fd_c    = 1'b0;
    flush_dx_c    = 1'b0;
    md_timeout_c  = 1'b0;
    cap_valid     = pend_valid_q;
    cap_target    = pend_target_q;

    case (state_q)
      ST_RUN: begin
        if (bus.trap_req) begin
          pc_in_c     = TRAP_VEC;
          use_pc_in_c = 1'b1;
          flush_fd_c  = 1'b1;
          flush_dx_c  = 1'b1;
          epc_d       = bus.pc_cur;
        end else if (bus.eret) begin
          pc_in_c     = epc_q;
          use_pc_in_c = 1'b1;
          flush_fd_c  = 1'b1;
          flush_dx_c  = 1'b1;
        end else if (bus.br_taken) begin
          pc_in_c     = bus.br_target;
          use_pc_in_c = 1'b1;
          flush_fd_c  = 1'b1;
          flush_dx_c  = 1'b1;
        end else if (bus.jmp_valid) begin
          pc_in_c     = bus.jmp_target;
          use_pc_in_c = 1'b1;
          flush_fd_c  = 1'b1;
        end else if (bus.md_start && !bus.md_ready) begin
          stall_c = 1'b1;
          state_d = ST_MD_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (bus.hazard_stall) begin
          stall_c = 1'b1;
        end
      end

      ST_MD_WAIT: begin
        // A trap always replaces what is parked; other redirects only fill an empty slot.
        if (bus.trap_req) begin
          cap_valid  = 1'b1;
          cap_target = TRAP_VEC;
          epc_d      = bus.pc_cur;
        end else if (!pend_valid_q) begin
          if (bus.eret) begin
            cap_valid  = 1'b1;
            cap_target = epc_q;
          end else if (bus.br_taken) begin
            cap_valid  = 1'b1;
            cap_target = bus.br_target;
          end else if (bus.jmp_valid) begin
            cap_valid  = 1'b1;
            cap_target = bus.jmp_target;
          end
        end

        if (bus.md_ready) begin
          if (cap_valid) begin
            pc_in_c     = cap_target;
            use_pc_in_c = 1'b1;
            flush_fd_c  = 1'b1;
            flush_dx_c  = 1'b1;
          end
          pend_valid_d  = 1'b0;
          pend_target_d = '0;
          cnt_d         = '0;
          state_d       = ST_RUN;
        end else if (cnt_q >= CNT_LAST) begin
          md_timeout_c  = 1'b1;
          pc_in_c       = TRAP_VEC;
          use_pc_in_c   = 1'b1;
          flush_fd_c    = 1'b1;
          flush_dx_c    = 1'b1;
          epc_d         = bus.pc_cur;
          pend_valid_d  = 1'b0;
          pend_target_d = '0;
          cnt_d         = '0;
          state_d       = ST_RUN;
        end else begin
          stall_c       = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          pend_valid_d  = cap_valid;
          pend_target_d = cap_target;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pc_in      = pc_in_c;
  assign bus.use_pc_in  = use_pc_in_c;
  assign bus.isStall    = stall_c;
  assign bus.flush_fd   = flush_fd_c;
  assign bus.flush_dx   = flush_dx_c;
  assign bus.epc        = epc_q;
  assign bus.md_timeout = md_timeout_c;

`ifdef PC_SCHED_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  always_comb begin
    stall_cycles_d   = stall_cycles_q + 32'(stall_c);
    redirect_count_d = redirect_count_q + 32'(use_pc_in_c);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.stall_cycles   = stall_cycles_q;
  assign bus.redirect_count = redirect_count_q;
`else
  assign bus.stall_cycles   = 32'd0;
  assign bus.redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sched.sv
// Directed scoreboard bench for pc_sched; a second instance with MD_TIMEOUT=4 covers the timeout path.
module tb_pc_sched;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] TV = 32'd1;

  typedef struct packed {
    logic [W-1:0] pc_in;
    logic         use_pc;
    logic         stall;
    logic         ffd;
    logic         fdx;
    logic         tmo;
  } ctl_t;

  logic         clock;
  logic         clrn;
  logic [W-1:0] pc_cur;
  logic         hz, mds, mdr, br, jv, trap, eret;
  logic [W-1:0] brt, jt;

  ctl_t sb_q[$];
  int   n_vec;
  int   n_err;
  bit   sel4;

  pc_sched_if #(.WIDTH(W)) bus ();
  pc_sched_if #(.WIDTH(W)) bus4 ();

  pc_sched #(.WIDTH(W), .TRAP_VEC(TV), .MD_TIMEOUT(64)) u_dut (
    .clock(clock), .clrn(clrn), .bus(bus)
  );
  pc_sched #(.WIDTH(W), .TRAP_VEC(TV), .MD_TIMEOUT(4)) u_dut4 (
    .clock(clock), .clrn(clrn), .bus(bus4)
  );

  assign bus.pc_cur        = pc_cur;
  assign bus.hazard_stall  = hz;
  assign bus.md_start      = mds;
  assign bus.md_ready      = mdr;
  assign bus.br_taken      = br;
  assign bus.br_target     = brt;
  assign bus.jmp_valid     = jv;
  assign bus.jmp_target    = jt;
  assign bus.trap_req      = trap;
  assign bus.eret          = eret;
  assign bus4.pc_cur       = pc_cur;
  assign bus4.hazard_stall = hz;
  assign bus4.md_start     = mds;
  assign bus4.md_ready     = mdr;
  assign bus4.br_taken     = br;
  assign bus4.br_target    = brt;
  assign bus4.jmp_valid    = jv;
  assign bus4.jmp_target   = jt;
  assign bus4.trap_req     = trap;
  assign bus4.eret         = eret;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic ctl_t mk(input logic [W-1:0] pc, input logic u, input logic s,
                              input logic ff, input logic fx, input logic t);
    ctl_t c;
    c.pc_in  = pc;
    c.use_pc = u;
    c.stall  = s;
    c.ffd    = ff;
    c.fdx    = fx;
    c.tmo    = t;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    hz = 1'b0; mds = 1'b0; mdr = 1'b0; br = 1'b0; jv = 1'b0; trap = 1'b0; eret = 1'b0;
    brt = '0; jt = '0;
  endtask

  // Push expectation, let combinational outputs settle, pop and compare, then advance one cycle.
  task automatic tick(input string tag, input ctl_t e);
    ctl_t o;
    ctl_t x;
    sb_q.push_back(e);
    #1;
    if (sel4)
      o = mk(bus4.pc_in, bus4.use_pc_in, bus4.isStall, bus4.flush_fd, bus4.flush_dx, bus4.md_timeout);
    else
      o = mk(bus.pc_in, bus.use_pc_in, bus.isStall, bus.flush_fd, bus.flush_dx, bus.md_timeout);
    x = sb_q.pop_front();
    chk({tag, ".pc_in"},      o.pc_in,      x.pc_in);
    chk({tag, ".use_pc_in"},  W'(o.use_pc), W'(x.use_pc));
    chk({tag, ".isStall"},    W'(o.stall),  W'(x.stall));
    chk({tag, ".flush_fd"},   W'(o.ffd),    W'(x.ffd));
    chk({tag, ".flush_dx"},   W'(o.fdx),    W'(x.fdx));
    chk({tag, ".md_timeout"}, W'(o.tmo),    W'(x.tmo));
    @(negedge clock);
    clr_inputs();
  endtask

  initial begin
    ctl_t z;
    ctl_t st;
    z  = mk('0, 0, 0, 0, 0, 0);
    st = mk('0, 0, 1, 0, 0, 0);
    n_vec = 0; n_err = 0; sel4 = 1'b0;
    clrn = 1'b0; pc_cur = '0;
    clr_inputs();

    tick("reset", z);
    chk("reset.epc", bus.epc, '0);
    chk("reset.stall_cycles", bus.stall_cycles, 32'd0);
    chk("reset.redirect_count", bus.redirect_count, 32'd0);
    clrn = 1'b1;

    for (int i = 0; i < 5; i++) tick("idle", z);

    br = 1; brt = 32'h40; jv = 1; jt = 32'h80;
    tick("br_over_jmp", mk(32'h40, 1, 0, 1, 1, 0));
    jv = 1; jt = 32'h80;
    tick("jmp_only", mk(32'h80, 1, 0, 1, 0, 0));
    hz = 1;
    tick("hazard", st);
    mds = 1; mdr = 1;
    tick("md_same_cycle", z);
    mds = 1; br = 1; brt = 32'h44;
    tick("md_vs_br", mk(32'h44, 1, 0, 1, 1, 0));
    tick("md_vs_br.after", z);

    mds = 1;
    tick("mdw.c0", st);
    tick("mdw.c1", st);
    jv = 1; jt = 32'h20;
    tick("mdw.c2", st);
    tick("mdw.c3", st);
    mdr = 1;
    tick("mdw.c4", mk(32'h20, 1, 0, 1, 1, 0));
    tick("mdw.c5", z);

    pc_cur = 32'h13; trap = 1;
    tick("trap", mk(TV, 1, 0, 1, 1, 0));
    chk("trap.epc", bus.epc, 32'h13);
    pc_cur = 32'h14;
    tick("trap.idle1", z);
    tick("trap.idle2", z);
    eret = 1;
    tick("eret", mk(32'h13, 1, 0, 1, 1, 0));

    pc_cur = 32'h77; mds = 1;
    tick("ovr.c0", st);
    br = 1; brt = 32'h50;
    tick("ovr.c1", st);
    trap = 1;
    tick("ovr.c2", st);
    chk("ovr.epc", bus.epc, 32'h77);
    mdr = 1;
    tick("ovr.c3", mk(TV, 1, 0, 1, 1, 0));

    mds = 1;
    tick("keep.c0", st);
    jv = 1; jt = 32'h90;
    tick("keep.c1", st);
    br = 1; brt = 32'hA0;
    tick("keep.c2", st);
    mdr = 1;
    tick("keep.c3", mk(32'h90, 1, 0, 1, 1, 0));

    mds = 1;
    tick("rdy_br.c0", st);
    hz = 1;
    tick("rdy_br.c1", st);
    mdr = 1; br = 1; brt = 32'h33;
    tick("rdy_br.c2", mk(32'h33, 1, 0, 1, 1, 0));

    sel4 = 1'b1; pc_cur = 32'h2A; mds = 1;
    tick("tmo.c0", st);
    tick("tmo.c1", st);
    tick("tmo.c2", st);
    tick("tmo.c3", mk(TV, 1, 0, 1, 1, 1));
    chk("tmo.epc", bus4.epc, 32'h2A);
    sel4 = 1'b0; mdr = 1;
    tick("tmo.main_release", z);

    mds = 1;
    tick("rstw.c0", st);
    br = 1; brt = 32'h55;
    tick("rstw.c1", st);
    clrn = 1'b0;
    tick("rstw.in_reset", z);
    chk("rstw.epc", bus.epc, '0);
    clrn = 1'b1; mdr = 1;
    tick("rstw.no_pending", z);

    for (int i = 0; i < 3; i++) begin
      hz = 1;
      tick("perf.hz", st);
    end
    br = 1; brt = 32'h60;
    tick("perf.br", mk(32'h60, 1, 0, 1, 1, 0));
`ifdef PC_SCHED_PERF_CNT_EN
    chk("perf.stall_cycles", bus.stall_cycles, 32'd3);
    chk("perf.redirect_count", bus.redirect_count, 32'd1);
`else
    chk("perf.stall_cycles", bus.stall_cycles, 32'd0);
    chk("perf.redirect_count", bus.redirect_count, 32'd0);
`endif
    chk("sb.empty", W'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
